sevenseg_scanner: RTL and testbench
===================================

Name: sevenseg_scanner

Overview:
Parametrised N-digit multiplexed seven-segment driver. It is the successor to the fixed 4-digit, digit-0-only driver.
- Internal scan prescaler and per-digit anode rotation.
- Anti-ghosting blank window between digits.
- Frame-synchronous double-buffered display data.
- Leading-zero blanking, optional hex glyphs and per-digit blink.
- Sits between the score/timer logic and the board's anode/segment pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..8).
CLK_HZ, 100_000_000, input clock frequency.
REFRESH_HZ, 1000, full-frame refresh rate; SCAN_DIV = CLK_HZ/(REFRESH_HZ*NUM_DIGITS) clocks per digit slot, must be >= BLANK_CYC+2.
BLANK_CYC, 4, clocks at the start of each slot with all anodes off.
BLINK_FRAMES, 250, frames per blink half-period.
AN_ACTIVE_LOW, 1, anode polarity (1 = active-low).
SEG_ACTIVE_LOW, 1, segment/dp polarity (1 = active-low).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
digits  in  4*NUM_DIGITS  nibble i = digit i (digit 0 = rightmost)
dps  in  NUM_DIGITS  decimal point request per digit
blink_mask  in  NUM_DIGITS  1 = digit blinks
load  in  1  one-cycle strobe; captures digits/dps/blink_mask into pending buffer
blank_lz  in  1  enable leading-zero blanking
hex_en  in  1  1 = show A-F for 10-15; 0 = blank for 10-15
an  out  NUM_DIGITS  anode enables
seg  out  7  segments {g,f,e,d,c,b,a}
dp  out  1  decimal point
frame_done  out  1  one-cycle pulse when slot NUM_DIGITS-1 ends

Behaviour:
- Reset (rst_n low, async): an and seg all inactive, dp inactive, frame_done 0. sel=0, slot counter=0, state=BLANK, pending/active buffers 0, pending_valid 0, blink phase 0.
- Slot counter counts 0..SCAN_DIV-1. FSM:
  - BLANK while count < BLANK_CYC; then DRIVE until count = SCAN_DIV-1.
  - At SCAN_DIV-1: sel <= (sel==NUM_DIGITS-1) ? 0 : sel+1; count <= 0; state <= BLANK.
- Outputs are registered, valid one clock after the state/sel they reflect. In BLANK, an, seg and dp are all inactive.
- In DRIVE, only an[sel] is active; seg = glyph(active digit sel); dp = active dps[sel].
- Buffering:
  - load copies inputs to pending and sets pending_valid.
  - At the frame boundary (sel wraps NUM_DIGITS-1 -> 0): if pending_valid, pending -> active and pending_valid clears.
  - load coincident with the boundary cycle: the input values are committed directly to active, and pending_valid stays 0.
  - Multiple loads within one frame: last wins.
- Leading-zero blanking (blank_lz=1): scanning from MSD, digits equal to 0 are blanked until the first nonzero digit. Digit 0 is never blanked. dp of a blanked digit is still shown. Evaluated on the active buffer.
- Glyphs: 0-9 always shown; 10-15 show A,b,C,d,E,F if hex_en=1, else blank.
- Blink: the phase counter counts frames and toggles the phase every BLINK_FRAMES frames. When phase=1, digits with active blink_mask set have seg and dp inactive; the anode still follows the scan.
- frame_done is asserted for the single clock in which sel wraps. It is registered, aligned with the sel update.
- Polarity is applied only at the output registers; internal logic is active-high.
- Reset mid-frame: immediate return to reset values. The first DRIVE after release is digit 0.

Optional Feature:
SEVENSEG_DIM_EN:
- Defined: adds input brightness[3:0] and a 4-bit free-running PWM counter. In DRIVE, an[sel] is active only when pwm < brightness, or when brightness = 15 (always on). brightness 0 = dark. seg/dp are unaffected.
- Undefined: no port and no counter; full brightness.

Decomposition:
- Package sevenseg_pkg holds:
  - FSM state enum {BLANK, DRIVE}.
  - 16-entry active-high glyph constant table (0-F).
  - GLYPH_BLANK = 7'h00 (active-high).
  - Function for SCAN_DIV computation.
- Sub-module sevenseg_tick_gen: slot counter + BLANK/DRIVE FSM + sel rotation + frame_done. Exports state, sel and frame strobe.
- Top level holds the buffers, blanking/blink logic, encoding and output registers.

Test Plan:
- Config NUM_DIGITS=4, CLK_HZ=1600, REFRESH_HZ=100 (SCAN_DIV=4), BLANK_CYC=1. Load digits=16'h1234, then idle -> each 4-clock slot has 1 clock with an=4'b1111, then 3 clocks with an=4'b1110 and seg=7'b0011001 ("4"). Digits appear in order 0,1,2,3. frame_done pulses every 16 clocks.
- Load 16'h0007 with blank_lz=1 -> digits 3..1 show seg=7'h7F and digit 0 shows 7'b1111000. Same with blank_lz=0 -> digits 3..1 show 7'b1000000.
- digits=16'hABCD: hex_en=1 -> digit 0 seg shows "d". hex_en=0 -> all four slots show seg=7'h7F.
- Load 16'h1111 mid-frame at sel=1 -> slots 1-3 still show old data; new data appears from slot 0 of the next frame. A load on the wrap cycle appears in that very slot 0.
- BLINK_FRAMES=2, blink_mask=4'b0001 -> digit 0 dark for frames 2-3, lit for frames 4-5, etc.; other digits always lit.
- Assert rst_n low mid-DRIVE for 3 clocks -> an=4'b1111, seg=7'h7F, dp=1 immediately (async). After release, the first lit anode is an=4'b1110.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types, glyph table and scan-rate helper for the multiplexed seven-segment scanner.
package sevenseg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    // Active-high {g,f,e,d,c,b,a} patterns for 0-9, A, b, C, d, E, F.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int scan_div(input int clk_hz, input int refresh_hz, input int num_digits);
        return clk_hz / (refresh_hz * num_digits);
    endfunction

endpackage

// File: rtl/sevenseg_tick_gen.sv
// Slot timing for the scanner: per-slot counter, BLANK/DRIVE state, digit select rotation
// and the frame strobes (combinational wrap and registered frame_done).
module sevenseg_tick_gen
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 12500,
    parameter int BLANK_CYC  = 4,
    localparam int SEL_W     = $clog2(NUM_DIGITS),
    localparam int CNT_W     = $clog2(SCAN_DIV)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output scan_state_e      o_state,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_wrap,
    output logic             o_frame_done
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    scan_state_e      r_state;
    scan_state_e      w_state_nxt;
    logic             r_frame;
    logic             w_slot_end;
    logic             w_wrap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_sel   <= '0;
            r_state <= BLANK;
            r_frame <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_state <= w_state_nxt;
            r_frame <= w_wrap;
        end
    end

    // State always matches the counter value it sits beside: BLANK for the first BLANK_CYC counts.
    always_comb begin
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_sel_nxt   = r_sel;
        w_state_nxt = (w_cnt_nxt < BLANK_END) ? BLANK : DRIVE;
        w_slot_end  = (r_cnt == CNT_LAST);
        w_wrap      = w_slot_end && (r_sel == SEL_LAST);
        if (w_slot_end) begin
            w_cnt_nxt   = '0;
            w_state_nxt = BLANK;
            w_sel_nxt   = w_wrap ? '0 : r_sel + SEL_W'(1);
        end
    end

    assign o_state      = r_state;
    assign o_sel        = r_sel;
    assign o_wrap       = w_wrap;
    assign o_frame_done = r_frame;

endmodule

// File: rtl/sevenseg_scanner.sv
// N-digit multiplexed seven-segment driver with frame-synchronous double buffering,
// leading-zero blanking, hex glyphs and blink. Optional PWM dimming: SEVENSEG_DIM_EN.
module sevenseg_scanner
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_HZ         = 100_000_000,
    parameter int REFRESH_HZ     = 1000,
    parameter int BLANK_CYC      = 4,
    parameter int BLINK_FRAMES   = 250,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dps,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic                    hex_en,
`ifdef SEVENSEG_DIM_EN
    input  logic [3:0]              brightness,
`endif
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int SCAN_DIV = scan_div(CLK_HZ, REFRESH_HZ, NUM_DIGITS);
    localparam int SEL_W    = $clog2(NUM_DIGITS);
    localparam int BLK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [BLK_W-1:0]      BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;

    scan_state_e             w_state;
    logic [SEL_W-1:0]        w_sel;
    logic                    w_wrap;

    logic [4*NUM_DIGITS-1:0] r_pend_dig;
    logic [NUM_DIGITS-1:0]   r_pend_dps;
    logic [NUM_DIGITS-1:0]   r_pend_blk;
    logic                    r_pend_valid;
    logic [4*NUM_DIGITS-1:0] r_act_dig;
    logic [NUM_DIGITS-1:0]   r_act_dps;
    logic [NUM_DIGITS-1:0]   r_act_blk;

    logic [BLK_W-1:0]        r_blink_cnt;
    logic                    r_blink_phase;

    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic [3:0]              w_nib;
    logic [6:0]              w_glyph;
    logic                    w_dark;
    logic                    w_an_on;
    logic [NUM_DIGITS-1:0]   w_an_ah;
    logic [6:0]              w_seg_ah;
    logic                    w_dp_ah;

    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;

    sevenseg_tick_gen #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .BLANK_CYC  (BLANK_CYC)
    ) u_tick (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_state      (w_state),
        .o_sel        (w_sel),
        .o_wrap       (w_wrap),
        .o_frame_done (frame_done)
    );

    // A load on the wrap cycle bypasses pending so it shows in the very next slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_dig   <= '0;
            r_pend_dps   <= '0;
            r_pend_blk   <= '0;
            r_pend_valid <= 1'b0;
            r_act_dig    <= '0;
            r_act_dps    <= '0;
            r_act_blk    <= '0;
        end else if (w_wrap) begin
            if (load) begin
                r_act_dig    <= digits;
                r_act_dps    <= dps;
                r_act_blk    <= blink_mask;
                r_pend_valid <= 1'b0;
            end else if (r_pend_valid) begin
                r_act_dig    <= r_pend_dig;
                r_act_dps    <= r_pend_dps;
                r_act_blk    <= r_pend_blk;
                r_pend_valid <= 1'b0;
            end
        end else if (load) begin
            r_pend_dig   <= digits;
            r_pend_dps   <= dps;
            r_pend_blk   <= blink_mask;
            r_pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_wrap) begin
            if (r_blink_cnt == BLK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLK_W'(1);
            end
        end
    end

    // Walk down from the MSD; digit 0 is never a blanking candidate.
    always_comb begin
        logic v_seen_nz;
        v_seen_nz  = 1'b0;
        w_lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (r_act_dig[4*i +: 4] != 4'd0) begin
                v_seen_nz = 1'b1;
            end
            w_lz_blank[i] = blank_lz && !v_seen_nz;
        end
    end

`ifdef SEVENSEG_DIM_EN
    logic [3:0] r_pwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 4'd1;
        end
    end

    assign w_an_on = (brightness == 4'hF) || (r_pwm < brightness);
`else
    assign w_an_on = 1'b1;
`endif

    always_comb begin
        w_nib    = r_act_dig[{w_sel, 2'b00} +: 4];
        w_dark   = r_blink_phase && r_act_blk[w_sel];
        w_glyph  = GLYPH_TABLE[w_nib];
        w_an_ah  = '0;
        w_seg_ah = GLYPH_BLANK;
        w_dp_ah  = 1'b0;
        if ((w_nib > 4'd9) && !hex_en) begin
            w_glyph = GLYPH_BLANK;
        end
        if (w_state == DRIVE) begin
            w_an_ah[w_sel] = w_an_on;
            w_seg_ah       = (w_lz_blank[w_sel] || w_dark) ? GLYPH_BLANK : w_glyph;
            w_dp_ah        = r_act_dps[w_sel] && !w_dark;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
            r_dp  <= DP_OFF;
        end else begin
            r_an  <= w_an_ah ^ AN_OFF;
            r_seg <= w_seg_ah ^ SEG_OFF;
            r_dp  <= w_dp_ah ^ DP_OFF;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Scoreboard bench for sevenseg_scanner: 4 digits, 4-clock slots with 1 blank clock, 2-frame blink.
module tb_sevenseg_scanner;

    localparam logic [6:0] S_0   = 7'h40;
    localparam logic [6:0] S_1   = 7'h79;
    localparam logic [6:0] S_2   = 7'h24;
    localparam logic [6:0] S_3   = 7'h30;
    localparam logic [6:0] S_4   = 7'h19;
    localparam logic [6:0] S_5   = 7'h12;
    localparam logic [6:0] S_7   = 7'h78;
    localparam logic [6:0] S_8   = 7'h00;
    localparam logic [6:0] S_A   = 7'h08;
    localparam logic [6:0] S_B   = 7'h03;
    localparam logic [6:0] S_C   = 7'h46;
    localparam logic [6:0] S_D   = 7'h21;
    localparam logic [6:0] S_OFF = 7'h7F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dps;
    logic [3:0]  blink_mask;
    logic        load;
    logic        blank_lz;
    logic        hex_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    logic [11:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc;

    always #5 clk = ~clk;

    sevenseg_scanner #(
        .NUM_DIGITS     (4),
        .CLK_HZ         (1600),
        .REFRESH_HZ     (100),
        .BLANK_CYC      (1),
        .BLINK_FRAMES   (2),
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits     (digits),
        .dps        (dps),
        .blink_mask (blink_mask),
        .load       (load),
        .blank_lz   (blank_lz),
        .hex_en     (hex_en),
`ifdef SEVENSEG_DIM_EN
        .brightness (4'hF),
`endif
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Each lit slot presents three clocks of {an, seg, dp}.
    task automatic exp_slot(input int s, input logic [6:0] sg, input logic dp_on, input int n);
        logic [3:0] a;
        a    = 4'hF;
        a[s] = 1'b0;
        repeat (n) exp_q.push_back({a, sg, ~dp_on});
    endtask

    task automatic exp_frame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                             input logic [6:0] s0, input logic [3:0] dp_on);
        exp_slot(0, s0, dp_on[0], 3);
        exp_slot(1, s1, dp_on[1], 3);
        exp_slot(2, s2, dp_on[2], 3);
        exp_slot(3, s3, dp_on[3], 3);
    endtask

    task automatic load_now(input logic [15:0] d, input logic [3:0] dv, input logic [3:0] bm);
        digits     = d;
        dps        = dv;
        blink_mask = bm;
        load       = 1'b1;
        tick(1);
        load       = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monitor: any lit anode is an output event that consumes one expected entry.
    always @(negedge clk) begin
        logic [11:0] e;
        if (an !== 4'hF) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL lit_unexpected at cycle %0d: an=%b seg=%b dp=%b, required all anodes off",
                         cyc, an, seg, dp);
            end else begin
                e = exp_q.pop_front();
                check("scan_out {an,seg,dp}", {20'd0, an, seg, dp}, {20'd0, e});
            end
        end else begin
            check("blank_seg_dp", {24'd0, seg, dp}, 32'hFF);
        end
        check("frame_done", {31'd0, frame_done}, {31'd0, (cyc != 0) && (cyc % 16 == 0)});
    end

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        digits     = '0;
        dps        = '0;
        blink_mask = '0;
        blank_lz   = 1'b0;
        hex_en     = 1'b1;
        tick(3);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'h1);
        check("rst_frame_done", {31'd0, frame_done}, 32'h0);
        rst_n = 1'b1;

        // Frame 0: empty active buffer shows zeros; load 1234 for frame 1.
        exp_frame(S_0, S_0, S_0, S_0, 4'b0000);
        tick(5); load_now(16'h1234, 4'b0100, 4'b0000); tick(10);
        // Frame 1
        exp_frame(S_1, S_2, S_3, S_4, 4'b0100);
        tick(7); load_now(16'h0007, 4'b0000, 4'b0000); tick(8);
        // Frame 2: leading zeros blanked
        blank_lz = 1'b1;
        exp_frame(S_OFF, S_OFF, S_OFF, S_7, 4'b0000);
        tick(16);
        // Frame 3: same data, blanking off
        blank_lz = 1'b0;
        exp_frame(S_0, S_0, S_0, S_7, 4'b0000);
        tick(2); load_now(16'h0102, 4'b1000, 4'b0000); tick(13);
        // Frame 4: interior zero kept, dp on blanked MSD still shown
        blank_lz = 1'b1;
        exp_frame(S_OFF, S_1, S_0, S_2, 4'b1000);
        tick(9); load_now(16'h0000, 4'b0000, 4'b0000); tick(6);
        // Frame 5: all zero, digit 0 never blanked
        exp_frame(S_OFF, S_OFF, S_OFF, S_0, 4'b0000);
        tick(1); load_now(16'hABCD, 4'b0000, 4'b0000); tick(14);
        // Frame 6: hex glyphs
        blank_lz = 1'b0;
        exp_frame(S_A, S_B, S_C, S_D, 4'b0000);
        tick(16);
        // Frame 7: hex disabled
        hex_en = 1'b0;
        exp_frame(S_OFF, S_OFF, S_OFF, S_OFF, 4'b0000);
        tick(16);
        // Frame 8: load at sel=1 must not disturb the current frame
        hex_en = 1'b1;
        exp_frame(S_A, S_B, S_C, S_D, 4'b0000);
        tick(5); load_now(16'h1111, 4'b0000, 4'b0000); tick(10);
        // Frame 9: load on the wrap cycle
        exp_frame(S_1, S_1, S_1, S_1, 4'b0000);
        tick(15); load_now(16'h4321, 4'b0001, 4'b0000);
        // Frame 10: two loads, last wins
        exp_frame(S_4, S_3, S_2, S_1, 4'b0001);
        tick(2); load_now(16'h9999, 4'b0000, 4'b0000); tick(5); load_now(16'h2580, 4'b0010, 4'b0000); tick(7);
        // Frame 11: load blinking digit 0
        exp_frame(S_2, S_5, S_8, S_0, 4'b0010);
        tick(3); load_now(16'h1234, 4'b0001, 4'b0001); tick(12);
        // Frames 12-16: phase is 1 in frames 14-15
        for (int f = 12; f <= 16; f++) begin
            if ((f == 14) || (f == 15)) exp_frame(S_1, S_2, S_3, S_OFF, 4'b0000);
            else                        exp_frame(S_1, S_2, S_3, S_4, 4'b0001);
            tick(16);
        end
        // Frame 17: reset in the middle of slot 0 DRIVE
        exp_slot(0, S_4, 1'b1, 1);
        tick(3);
        rst_n = 1'b0;
        #1;
        check("midrst_an", {28'd0, an}, 32'hF);
        check("midrst_seg", {25'd0, seg}, 32'h7F);
        check("midrst_dp", {31'd0, dp}, 32'h1);
        check("midrst_frame_done", {31'd0, frame_done}, 32'h0);
        tick(3);
        rst_n = 1'b1;
        exp_frame(S_0, S_0, S_0, S_0, 4'b0000);
        tick(16);
        exp_frame(S_0, S_0, S_0, S_0, 4'b0000);
        tick(18);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
